// File: rtl/and_resp_pkg.sv
// Shared definitions for the AND responder: opcodes, FIFO occupancy states
// and default sizing.
package and_resp_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_NAND = 2'b01,
        OP_ACC  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'b00,
        ST_PARTIAL = 2'b01,
        ST_FULL    = 2'b10
    } occ_e;

endpackage : and_resp_pkg

// File: rtl/and_resp_fifo.sv
// Result buffer: DEPTH-entry FIFO with wrapping pointers and an explicit
// EMPTY/PARTIAL/FULL occupancy state machine.
module and_resp_fifo
    import and_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int             AW   = $clog2(DEPTH);
    localparam int             CW   = AW + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt_q;
    occ_e             state_q;
    occ_e             state_d;
    logic             do_push;
    logic             do_pop;

    // Guard the handshakes locally so the buffer can never over/underflow.
    assign full    = (state_q == ST_FULL);
    assign empty   = (state_q == ST_EMPTY);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rd_data = mem[rd_ptr];

    // Storage write port.
    // NOTE: the data array has no reset; the occupancy state alone decides
    // which entries are meaningful, so clearing it is wasted hardware.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy count; power-of-two depth makes pointers wrap naturally.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: ;
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next-state; simultaneous push and pop leaves PARTIAL unchanged.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: begin
                if (do_push) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (do_push && !do_pop && cnt_q == LAST) begin
                    state_d = ST_FULL;
                end else if (do_pop && !do_push && cnt_q == CW'(1)) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (do_pop) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

endmodule : and_resp_fifo

// File: rtl/and_responder.sv
// AND responder: decodes AND/NAND/accumulate requests, buffers results in a
// FIFO and counts delivered results.
module and_responder
    import and_resp_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] acc,
    output logic [7:0]       count
);

    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // Handshakes are masked during reset so nothing presented then takes effect.
    assign in_ready  = reset | ~full;
    assign out_valid = ~reset & ~empty;
    assign y         = out_valid ? head : '0;
    assign push      = in_valid & in_ready & ~reset;
    assign pop       = out_valid & out_ready;

    // Opcode decode: result for the FIFO and the would-be accumulator value.
    always_comb begin
        result = a & b;
        acc_d  = acc;
        case (op_e'(op))
            OP_AND:  result = a & b;
            OP_NAND: result = ~(a & b);
            OP_ACC: begin
                result = acc & a & b;
                acc_d  = acc & a & b;
            end
            OP_CLR: begin
                result = '1;
                acc_d  = '1;
            end
            default: ;
        endcase
    end

    // Accumulator changes only on accepted requests (AND/NAND leave acc_d = acc).
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '1;
        end else if (push) begin
            acc <= acc_d;
        end
    end

    // Delivered-result counter, wrapping modulo 256.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (pop) begin
            count <= count + 8'd1;
        end
    end

    and_resp_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (result),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

endmodule : and_responder

// File: tb/tb_and_responder.sv
// Directed self-checking bench for and_responder (WIDTH=8, DEPTH=4).
module tb_and_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic [7:0] acc;
    logic [7:0] count;

    int tests  = 0;
    int failed = 0;

    logic [7:0] exp_q [$];
    logic [7:0] exp_head;
    int         exp_count;

    and_responder #(.WIDTH(8), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .acc       (acc),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic req(input logic [1:0] o, input logic [7:0] va, input logic [7:0] vb);
        in_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        op        = 2'b00;
        exp_count = 0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_y", y, 0);
        check("rst_count", count, 0);
        check("rst_acc", acc, 8'hFF);
        reset = 1'b0;
        tick();

        // AND F0 & 3C = 30, visible only after the accepting edge
        req(2'b00, 8'hF0, 8'h3C);
        check("and_no_bypass", out_valid, 0);
        tick();
        in_valid = 1'b0;
        check("and_valid", out_valid, 1);
        check("and_y", y, 8'h30);
        check("and_count_before", count, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("and_count", count, 1);
        check("and_drained", out_valid, 0);

        // NAND ~(FF & 0F) = F0
        req(2'b01, 8'hFF, 8'h0F);
        tick();
        in_valid = 1'b0;
        check("nand_y", y, 8'hF0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("nand_count", count, 2);

        // Accumulate sequence with consumer stalled
        req(2'b10, 8'hFE, 8'hFF);
        tick();
        check("acc1", acc, 8'hFE);
        req(2'b10, 8'hFD, 8'hFF);
        tick();
        check("acc2", acc, 8'hFC);
        req(2'b11, 8'h00, 8'h00);
        tick();
        in_valid = 1'b0;
        check("acc_clr", acc, 8'hFF);
        check("acc_hold_y", y, 8'hFE);
        tick();
        check("acc_stall_y", y, 8'hFE);
        check("acc_stall_valid", out_valid, 1);
        out_ready = 1'b1;
        check("drain0", y, 8'hFE);
        tick();
        check("drain1", y, 8'hFC);
        tick();
        check("drain2", y, 8'hFF);
        tick();
        out_ready = 1'b0;
        check("drain_empty", out_valid, 0);
        check("drain_count", count, 5);
        check("acc_after_pops", acc, 8'hFF);

        // Fill to DEPTH, refuse a fifth request, then free one slot
        for (int i = 1; i <= 4; i++) begin
            req(2'b00, 8'(8'h11 * i), 8'hFF);
            tick();
        end
        check("full_in_ready", in_ready, 0);
        req(2'b10, 8'h00, 8'h00);
        tick();
        check("refused_in_ready", in_ready, 0);
        check("refused_acc", acc, 8'hFF);
        out_ready = 1'b1;
        check("full_head", y, 8'h11);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("pop_in_ready", in_ready, 1);
        check("pop_next_head", y, 8'h22);
        check("pop_count", count, 6);
        out_ready = 1'b1;
        check("rest0", y, 8'h22);
        tick();
        check("rest1", y, 8'h33);
        tick();
        check("rest2", y, 8'h44);
        tick();
        out_ready = 1'b0;
        check("refused_not_stored", out_valid, 0);
        check("rest_count", count, 9);
        exp_count = 9;

        // Two entries buffered, then ten cycles of simultaneous push and pop
        req(2'b00, 8'hA0, 8'hFF);
        exp_q.push_back(8'hA0);
        tick();
        req(2'b00, 8'hA1, 8'hFF);
        exp_q.push_back(8'hA1);
        tick();
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req(2'b00, 8'(8'hB0 + k), 8'hFF);
            exp_head = exp_q.pop_front();
            exp_q.push_back(8'(8'hB0 + k));
            check("stream_y", y, exp_head);
            tick();
            exp_count++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("stream_in_ready", in_ready, 1);
        check("stream_count", count, exp_count);
        // Exactly two more pushes must fill it if occupancy stayed at 2
        req(2'b00, 8'hC0, 8'hFF);
        exp_q.push_back(8'hC0);
        tick();
        check("occ3_in_ready", in_ready, 1);
        req(2'b00, 8'hC1, 8'hFF);
        exp_q.push_back(8'hC1);
        tick();
        in_valid = 1'b0;
        check("occ4_in_ready", in_ready, 0);
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            exp_head = exp_q.pop_front();
            check("order_y", y, exp_head);
            tick();
            exp_count++;
        end
        out_ready = 1'b0;
        check("order_empty", out_valid, 0);

        // Stream until 300 results delivered (count wraps), leave 3 buffered
        req(2'b00, 8'h5A, 8'hFF);
        tick();
        out_ready = 1'b1;
        while (exp_count < 300) begin
            tick();
            exp_count++;
        end
        out_ready = 1'b0;
        check("wrap_count", count, 8'(300 % 256));
        req(2'b10, 8'h3C, 8'hFF);
        tick();
        req(2'b10, 8'h0F, 8'hFF);
        tick();
        in_valid = 1'b0;
        check("pre_rst_acc", acc, 8'h0C);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_head", y, 8'h5A);

        // Mid-operation reset with a request and a pop presented in that cycle
        reset     = 1'b1;
        out_ready = 1'b1;
        req(2'b10, 8'h00, 8'h00);
        tick();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_acc", acc, 8'hFF);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_y", y, 0);
        tick();
        check("post_rst_valid", out_valid, 0);
        check("post_rst_count", count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_and_responder

// File: doc/and_responder.md
AND_RESPONDER -- requirements
Module: and_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, result buffer entries; power of two, at least 2.
REQ-003 SHALL have one clock and a synchronous, active-high reset, named as listed below.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand request present.
REQ-007 in_ready  output  1  responder can accept a request this cycle.
REQ-008 a  input  WIDTH  first operand.
REQ-009 b  input  WIDTH  second operand.
REQ-010 op  input  2  request opcode: 00 AND, 01 NAND, 10 AND-accumulate, 11 clear-accumulate.
REQ-011 out_valid  output  1  buffered result available.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 y  output  WIDTH  head-of-buffer result.
REQ-014 acc  output  WIDTH  current accumulator value.
REQ-015 count  output  8  number of results delivered, modulo 256.

Function
REQ-016 SHALL accept a request when in_valid and in_ready are both 1 at a rising edge; a, b and op are sampled only then.
REQ-017 SHALL compute the result per op:
- AND: a & b
- NAND: ~(a & b)
- AND-accumulate: acc & a & b, with acc updated to the same value
- clear-accumulate: all ones, with acc set to all ones
REQ-018 SHALL push each accepted result into a FIFO of DEPTH entries in acceptance order.
REQ-019 SHALL drive in_ready = 1 exactly when the FIFO is not full; a pop in the same cycle SHALL NOT raise in_ready when full.
REQ-020 SHALL drive out_valid = 1 exactly when the FIFO is non-empty, with y equal to the oldest entry.
REQ-021 SHALL pop on a rising edge with out_valid and out_ready both 1, and increment count, wrapping 255 to 0.
REQ-022 Latency: a result accepted at edge N SHALL become visible on out_valid/y after edge N at the earliest; there is no combinational in-to-out bypass.
REQ-023 SHALL hold y and out_valid stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL track occupancy states EMPTY, PARTIAL and FULL:
- push only: EMPTY to PARTIAL; PARTIAL to FULL when occupancy reaches DEPTH
- pop only: FULL to PARTIAL; PARTIAL to EMPTY at occupancy 0
- simultaneous push and pop in PARTIAL: occupancy unchanged
- simultaneous push and pop in EMPTY: impossible, because out_valid = 0
REQ-025 SHALL update acc only on accepted AND-accumulate or clear-accumulate requests; acc SHALL be unaffected by pops and by refused requests.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH.
REQ-027 SHALL ignore out_ready while out_valid = 0 and ignore in_valid while in_ready = 0, with no state change.

Reset
REQ-028 While reset = 1 at an edge, the FIFO SHALL be emptied, state set to EMPTY, count set to 0 and acc set to all ones.
REQ-029 Under reset, out_valid SHALL be 0, in_ready SHALL be 1 and y SHALL be 0.
REQ-030 A reset asserted mid-operation SHALL discard all buffered results.
REQ-031 A request or pop presented in the reset cycle SHALL NOT take effect.

Structure
REQ-032 SHALL use a shared package and_resp_pkg holding the opcode enumeration (OP_AND, OP_NAND, OP_ACC, OP_CLR), the occupancy state enumeration and default WIDTH/DEPTH constants.
REQ-033 SHALL instantiate one sub-module, and_resp_fifo, parameterised by WIDTH and DEPTH, containing storage, pointers and occupancy state.
REQ-034 Opcode decoding, accumulator and count logic SHALL reside in and_responder.

Verification
REQ-035 Bench SHALL cover: reset, then AND a=0xF0 b=0x3C -> y=0x30 with out_valid one cycle later, then out_ready=1 -> count=1.
REQ-036 Bench SHALL cover: NAND a=0xFF b=0x0F -> y=0xF0.
REQ-037 Bench SHALL cover: with out_ready=0, ACC 0xFE/0xFF then ACC 0xFD/0xFF then CLR -> acc 0xFE, 0xFC, 0xFF; drain yields 0xFE, 0xFC, 0xFF in order.
REQ-038 Bench SHALL cover: with out_ready=0, 4 pushes -> in_ready=0; a 5th in_valid is refused; one pop -> in_ready=1 next cycle and first pushed value delivered.
REQ-039 Bench SHALL cover: with the FIFO holding 2 entries, simultaneous push and pop for 10 cycles -> occupancy stays 2 and order is preserved.
REQ-040 Bench SHALL cover: reset with 3 entries buffered and count=300 mod 256=44 -> out_valid=0, count=0, acc=0xFF next cycle.
